car_traffic: RTL

Generates the positions of the ten road cars for the Frogger-style game and flags frog/car collisions. Sits directly upstream of `vga_display`: its packed `car_x`/`car_y` buses are unpacked onto `vga_display`'s `car1_x..car10_y` ports. It also feeds `hit` to the game-control FSM. All motion is in grid units on the 20x15 grid of 32-pixel cells, advanced once per video frame tick.

---
 rtl/lastfrog_pkg.sv | 28 ++
 rtl/traffic_lane.sv | 83 ++++++++
 rtl/car_traffic.sv | 94 +++++++++
 3 files changed

// File: rtl/lastfrog_pkg.sv
// Grid geometry and lane helpers shared by the game's video, frog and traffic blocks.
package lastfrog_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int NUM_LANES = 5;
    localparam int NUM_CARS  = 10;
    localparam int COL_W     = 5;
    localparam int ROW_W     = 4;
    localparam int CNT_W     = 6;

    // Bit l set means lane l moves left (toward column 0); even lanes move right.
    localparam logic [NUM_LANES-1:0] LANE_DIR = 5'b01010;

    function automatic logic [CNT_W-1:0] lane_period(
        input logic signed [7:0] base,
        input logic signed [7:0] lane_step,
        input logic signed [7:0] level_step,
        input logic signed [7:0] min_period,
        input logic        [2:0] lane,
        input logic        [1:0] level
    );
        logic signed [7:0] p;
        p = base - lane_step * $signed({5'd0, lane}) - level_step * $signed({6'd0, level});
        return (p < min_period) ? min_period[CNT_W-1:0] : p[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/traffic_lane.sv
// One road lane: a frame counter paced by the lane period and two cars
// that always step together, wrapping at the grid edges.
module traffic_lane #(
    parameter int   LANE = 0,
    parameter logic DIR  = lastfrog_pkg::LANE_DIR[LANE],
    parameter int   COLS = lastfrog_pkg::GRID_COLS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           tick,
    input  logic [lastfrog_pkg::CNT_W-1:0] period,
    output logic [lastfrog_pkg::COL_W-1:0] col_a,
    output logic [lastfrog_pkg::COL_W-1:0] col_b,
    output logic                           move
);
    import lastfrog_pkg::*;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] INIT_A   = DIR ? COL_W'(COLS - 1) : COL_W'(0);
    localparam logic [COL_W-1:0] INIT_B   = DIR ? COL_W'(COLS / 2 - 1) : COL_W'(COLS / 2);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [COL_W-1:0] col_a_d, col_a_q;
    logic [COL_W-1:0] col_b_d, col_b_q;
    logic [CNT_W:0]   cnt_inc_s;
    logic             move_s;

    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] nxt;
        if (DIR) begin
            nxt = (col == COL_W'(0)) ? LAST_COL : col - COL_W'(1);
        end else begin
            nxt = (col == LAST_COL) ? COL_W'(0) : col + COL_W'(1);
        end
        return nxt;
    endfunction

    // One extra bit so the "reached period-1" test never underflows.
    assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Counter advance and car stepping; restart has priority over a tick.
    always_comb begin
        cnt_d   = cnt_q;
        col_a_d = col_a_q;
        col_b_d = col_b_q;
        move_s  = 1'b0;
        if (clear) begin
            cnt_d   = CNT_W'(0);
            col_a_d = INIT_A;
            col_b_d = INIT_B;
        end else if (tick) begin
            if (cnt_inc_s >= {1'b0, period}) begin
                cnt_d   = CNT_W'(0);
                col_a_d = next_col(col_a_q);
                col_b_d = next_col(col_b_q);
                move_s  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= CNT_W'(0);
            col_a_q <= INIT_A;
            col_b_q <= INIT_B;
        end else begin
            cnt_q   <= cnt_d;
            col_a_q <= col_a_d;
            col_b_q <= col_b_d;
        end
    end

    assign col_a = col_a_q;
    assign col_b = col_b_q;
    assign move  = move_s;

endmodule

// File: rtl/car_traffic.sv
// Road traffic for the Frogger-style game: five two-car lanes moving once per
// qualified frame tick, packed for vga_display, plus a registered frog/car hit flag.
module car_traffic #(
    parameter int GRID_COLS   = 20,
    parameter int LANE_ROW0   = 3,
    parameter int BASE_PERIOD = 30,
    parameter int LANE_STEP   = 4,
    parameter int LEVEL_STEP  = 6,
    parameter int MIN_PERIOD  = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  frame_tick,
    input  logic                                                  run,
    input  logic                                                  clear,
    input  logic [1:0]                                            level,
    input  logic [lastfrog_pkg::COL_W-1:0]                        frog_col,
    input  logic [lastfrog_pkg::ROW_W-1:0]                        frog_row,
    output logic [lastfrog_pkg::NUM_CARS*lastfrog_pkg::COL_W-1:0] car_x,
    output logic [lastfrog_pkg::NUM_CARS*lastfrog_pkg::ROW_W-1:0] car_y,
    output logic                                                  hit,
    output logic                                                  step
);
    import lastfrog_pkg::*;

    logic                 tick_s;
    logic [CNT_W-1:0]     period_s [NUM_LANES];
    logic [COL_W-1:0]     col_a_s  [NUM_LANES];
    logic [COL_W-1:0]     col_b_s  [NUM_LANES];
    logic [NUM_LANES-1:0] move_s;
    logic                 hit_d, hit_q;
    logic                 step_d, step_q;

    assign tick_s = frame_tick & run & ~clear;

    // Lane periods follow the level input combinationally, so a level change acts on the next tick.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            period_s[l] = lane_period(8'(BASE_PERIOD), 8'(LANE_STEP), 8'(LEVEL_STEP),
                                      8'(MIN_PERIOD), 3'(l), level);
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        traffic_lane #(
            .LANE (l),
            .DIR  (LANE_DIR[l]),
            .COLS (GRID_COLS)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear),
            .tick   (tick_s),
            .period (period_s[l]),
            .col_a  (col_a_s[l]),
            .col_b  (col_b_s[l]),
            .move   (move_s[l])
        );

        assign car_x[(2*l)*COL_W   +: COL_W] = col_a_s[l];
        assign car_x[(2*l+1)*COL_W +: COL_W] = col_b_s[l];
        assign car_y[(2*l)*ROW_W   +: ROW_W] = ROW_W'(LANE_ROW0 + l);
        assign car_y[(2*l+1)*ROW_W +: ROW_W] = ROW_W'(LANE_ROW0 + l);
    end

    // Collision is checked against the registered car columns, independent of run.
    always_comb begin
        hit_d = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if ((frog_row == ROW_W'(LANE_ROW0 + l)) &&
                ((col_a_s[l] == frog_col) || (col_b_s[l] == frog_col))) begin
                hit_d = 1'b1;
            end else begin
                hit_d = hit_d;
            end
        end
        step_d = |move_s;
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            step_q <= step_d;
        end
    end

    assign hit  = hit_q;
    assign step = step_q;

endmodule
